// File: rtl/load_store_unit_if.sv
// Request, data-memory and response signal bundle for the load/store unit.
// slave is the unit itself; master is whatever drives requests, models memory and takes responses.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        is_load;
    logic        is_store;
    logic [31:0] base;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [2:0]  funct3;
    logic [4:0]  rd;

    logic [31:0] mem_addr;
    logic [31:0] mem_value;
    logic [2:0]  mem_funct3;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_data;

    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_fault;

    modport slave (
        input  req_valid, is_load, is_store, base, offset, store_data, funct3, rd,
        output req_ready,
        output mem_addr, mem_value, mem_funct3, mem_read, mem_write,
        input  mem_data,
        output resp_valid, resp_data, resp_rd, resp_fault,
        input  resp_ready
    );

    modport master (
        output req_valid, is_load, is_store, base, offset, store_data, funct3, rd,
        input  req_ready,
        input  mem_addr, mem_value, mem_funct3, mem_read, mem_write,
        output mem_data,
        input  resp_valid, resp_data, resp_rd, resp_fault,
        output resp_ready
    );
endinterface

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with fault checks; MISALIGN_TRAP_EN adds alignment faults.
// Latency from acceptance to resp_valid: load 3, store 2, fault 1 cycle.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
module load_store_unit #(
    parameter int MEMSIZE = 64
) (
    input  logic              clk,
    input  logic              rst,
    load_store_unit_if.slave  lsu
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_next;

    logic [31:0] r_ea;
    logic [31:0] r_store_data;
    logic [2:0]  r_funct3;
    logic        r_is_load;
    logic        r_is_store;
    logic [31:0] r_resp_data;
    logic [4:0]  r_resp_rd;
    logic        r_resp_fault;

    logic [31:0] w_ea;
    logic        w_accept;
    logic        w_range_flt;
    logic        w_type_flt;
    logic        w_f3_flt;
    logic        w_mis_flt;
    logic        w_fault;
    logic        w_access;

    assign w_ea        = lsu.base + lsu.offset;
    assign w_accept    = lsu.req_valid && (r_state == IDLE);
    assign w_range_flt = (w_ea >= 32'(MEMSIZE));
    assign w_type_flt  = (lsu.is_load == lsu.is_store);
    assign w_f3_flt    = (lsu.is_load && ((lsu.funct3 == 3'd3) || (lsu.funct3 == 3'd6) ||
                                          (lsu.funct3 == 3'd7))) ||
                         (lsu.is_store && (lsu.funct3 > 3'd2));
`ifdef MISALIGN_TRAP_EN
    assign w_mis_flt   = (((lsu.funct3 == 3'd1) || (lsu.funct3 == 3'd5)) && w_ea[0]) ||
                         ((lsu.funct3 == 3'd2) && (w_ea[1:0] != 2'b00));
`else
    assign w_mis_flt   = 1'b0;
`endif
    assign w_fault     = w_range_flt || w_type_flt || w_f3_flt || w_mis_flt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_next = w_fault ? RESP : ACCESS;
            ACCESS:  w_next = r_is_load ? WAIT : RESP;
            WAIT:    w_next = RESP;
            RESP:    if (lsu.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Response payload is cleared at acceptance so faults and stores return zero data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ea         <= '0;
            r_store_data <= '0;
            r_funct3     <= '0;
            r_is_load    <= 1'b0;
            r_is_store   <= 1'b0;
            r_resp_data  <= '0;
            r_resp_rd    <= '0;
            r_resp_fault <= 1'b0;
        end else if (w_accept) begin
            r_ea         <= w_ea;
            r_store_data <= lsu.store_data;
            r_funct3     <= lsu.funct3;
            r_is_load    <= lsu.is_load;
            r_is_store   <= lsu.is_store;
            r_resp_data  <= '0;
            r_resp_rd    <= lsu.rd;
            r_resp_fault <= w_fault;
        end else if (r_state == WAIT) begin
            r_resp_data  <= lsu.mem_data;
        end
    end

    // Memory drive is decoded from state so a reset drops it without waiting for a clock.
    assign w_access       = (r_state == ACCESS);
    assign lsu.mem_read   = w_access && r_is_load;
    assign lsu.mem_write  = w_access && r_is_store;
    assign lsu.mem_addr   = w_access ? r_ea         : 32'd0;
    assign lsu.mem_value  = w_access ? r_store_data : 32'd0;
    assign lsu.mem_funct3 = w_access ? r_funct3     : 3'd0;

    assign lsu.req_ready  = (r_state == IDLE);
    assign lsu.resp_valid = (r_state == RESP);
    assign lsu.resp_data  = r_resp_data;
    assign lsu.resp_rd    = r_resp_rd;
    assign lsu.resp_fault = r_resp_fault;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed vector bench for load_store_unit with a registered-read memory model.
module tb_load_store_unit;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    load_store_unit_if bus ();

    load_store_unit #(.MEMSIZE(64)) dut (
        .clk (clk),
        .rst (rst),
        .lsu (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [0:63];

    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 64; j++) mem[j] <= 32'd0;
            mem[4]  <= 32'h0000_0044;
            mem[6]  <= 32'h0000_0066;
            mem[8]  <= 32'h0000_0088;
            mem[12] <= 32'hDEAD_BEEF;
            mem[63] <= 32'h0000_007F;
            bus.mem_data <= 32'd0;
        end else begin
            if (bus.mem_read)  bus.mem_data <= mem[bus.mem_addr[5:0]];
            if (bus.mem_write) mem[bus.mem_addr[5:0]] <= bus.mem_value;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [31:0] base;
        logic [31:0] offset;
        logic [31:0] sd;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [4:0]  rd;
        logic        flt;
        int          lat;
        int          nrd;
        int          nwr;
        logic [31:0] addr;
        logic [31:0] val;
        logic [31:0] data;
    } vec_t;

    localparam int NV = 16;
    vec_t vecs [NV];

    task automatic drive_req(input logic [31:0] b, input logic [31:0] o, input logic [31:0] sd,
                             input logic ld, input logic st, input logic [2:0] f3,
                             input logic [4:0] rd);
        bus.base       = b;
        bus.offset     = o;
        bus.store_data = sd;
        bus.is_load    = ld;
        bus.is_store   = st;
        bus.funct3     = f3;
        bus.rd         = rd;
        bus.req_valid  = 1'b1;
    endtask

    initial begin
        int nrd, nwr, lat, nresp;
        logic [31:0] addr, val, data;
        logic [2:0]  f3s;
        logic        flt;
        logic [4:0]  rdv;

        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b0;
        drive_req(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 3'd0, 5'd0);
        bus.req_valid = 1'b0;

        //                base          offset  sd            ld    st    f3    rd     flt   lat nrd nwr addr    val           data
        vecs[0]  = '{32'd8,        32'd4,  32'd0,        1'b1, 1'b0, 3'd2, 5'd5,  1'b0, 3, 1, 0, 32'd12, 32'd0,        32'hDEADBEEF};
        vecs[1]  = '{32'd3,        32'd0,  32'h55,       1'b0, 1'b1, 3'd0, 5'd1,  1'b0, 2, 0, 1, 32'd3,  32'h55,       32'd0};
        vecs[2]  = '{32'd60,       32'd8,  32'd0,        1'b1, 1'b0, 3'd2, 5'd2,  1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[3]  = '{32'd4,        32'd0,  32'd0,        1'b1, 1'b1, 3'd2, 5'd3,  1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[4]  = '{32'd4,        32'd0,  32'd0,        1'b0, 1'b0, 3'd2, 5'd4,  1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[5]  = '{32'd4,        32'd0,  32'd0,        1'b1, 1'b0, 3'd3, 5'd6,  1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[6]  = '{32'd4,        32'd0,  32'd0,        1'b1, 1'b0, 3'd6, 5'd7,  1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[7]  = '{32'd4,        32'd0,  32'd0,        1'b1, 1'b0, 3'd7, 5'd8,  1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[8]  = '{32'd4,        32'd0,  32'h11,       1'b0, 1'b1, 3'd3, 5'd9,  1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[9]  = '{32'd63,       32'd0,  32'd0,        1'b1, 1'b0, 3'd0, 5'd10, 1'b0, 3, 1, 0, 32'd63, 32'd0,        32'h7F};
        vecs[10] = '{32'd64,       32'd0,  32'd0,        1'b1, 1'b0, 3'd0, 5'd16, 1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
        vecs[11] = '{32'hFFFFFFFF, 32'd5,  32'd0,        1'b1, 1'b0, 3'd4, 5'd11, 1'b0, 3, 1, 0, 32'd4,  32'd0,        32'h44};
        vecs[12] = '{32'd16,       32'd4,  32'hCAFEF00D, 1'b0, 1'b1, 3'd2, 5'd12, 1'b0, 2, 0, 1, 32'd20, 32'hCAFEF00D, 32'd0};
        vecs[13] = '{32'd20,       32'd0,  32'd0,        1'b1, 1'b0, 3'd2, 5'd13, 1'b0, 3, 1, 0, 32'd20, 32'd0,        32'hCAFEF00D};
`ifdef MISALIGN_TRAP_EN
        vecs[14] = '{32'd5,        32'd1,  32'd0,        1'b1, 1'b0, 3'd2, 5'd14, 1'b1, 1, 0, 0, 32'd0,  32'd0,        32'd0};
`else
        vecs[14] = '{32'd5,        32'd1,  32'd0,        1'b1, 1'b0, 3'd2, 5'd14, 1'b0, 3, 1, 0, 32'd6,  32'd0,        32'h66};
`endif
        vecs[15] = '{32'd8,        32'd0,  32'd0,        1'b1, 1'b0, 3'd5, 5'd15, 1'b0, 3, 1, 0, 32'd8,  32'd0,        32'h88};

        // Reset values must hold before any clock edge.
        #1;
        chk("rst_req_ready",  bus.req_ready,  32'd1);
        chk("rst_resp_valid", bus.resp_valid, 32'd0);
        chk("rst_resp_data",  bus.resp_data,  32'd0);
        chk("rst_resp_rd",    bus.resp_rd,    32'd0);
        chk("rst_resp_fault", bus.resp_fault, 32'd0);
        chk("rst_mem_read",   bus.mem_read,   32'd0);
        chk("rst_mem_write",  bus.mem_write,  32'd0);
        chk("rst_mem_addr",   bus.mem_addr,   32'd0);
        chk("rst_mem_value",  bus.mem_value,  32'd0);
        chk("rst_mem_funct3", bus.mem_funct3, 32'd0);
        drive_req(32'd8, 32'd4, 32'd0, 1'b1, 1'b0, 3'd2, 5'd5);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hold_ready", bus.req_ready, 32'd1);
        chk("rst_hold_read",  bus.mem_read,  32'd0);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            chk($sformatf("v%0d_req_ready", i), bus.req_ready, 32'd1);
            drive_req(vecs[i].base, vecs[i].offset, vecs[i].sd, vecs[i].ld, vecs[i].st,
                      vecs[i].f3, vecs[i].rd);
            @(posedge clk);
            #1 bus.req_valid = 1'b0;
            nrd = 0; nwr = 0; lat = 0; nresp = 0;
            addr = '0; val = '0; data = '0; flt = 1'b0; rdv = '0; f3s = '0;
            for (int k = 1; k <= 6; k++) begin
                @(negedge clk);
                if (bus.mem_read)  begin nrd++; addr = bus.mem_addr; f3s = bus.mem_funct3; end
                if (bus.mem_write) begin nwr++; addr = bus.mem_addr; val = bus.mem_value; f3s = bus.mem_funct3; end
                if (bus.resp_valid) nresp++;
                if (bus.resp_valid && lat == 0) begin
                    lat = k;
                    data = bus.resp_data;
                    flt = bus.resp_fault;
                    rdv = bus.resp_rd;
                    chk($sformatf("v%0d_idle_addr", i), bus.mem_addr, 32'd0);
                    bus.resp_ready = 1'b1;
                end else begin
                    bus.resp_ready = 1'b0;
                end
            end
            chk($sformatf("v%0d_latency", i), lat,   vecs[i].lat);
            chk($sformatf("v%0d_nresp", i),   nresp, 32'd1);
            chk($sformatf("v%0d_fault", i),   flt,   vecs[i].flt);
            chk($sformatf("v%0d_data", i),    data,  vecs[i].data);
            chk($sformatf("v%0d_rd", i),      rdv,   vecs[i].rd);
            chk($sformatf("v%0d_nread", i),   nrd,   vecs[i].nrd);
            chk($sformatf("v%0d_nwrite", i),  nwr,   vecs[i].nwr);
            if (vecs[i].nrd + vecs[i].nwr > 0) begin
                chk($sformatf("v%0d_addr", i),   addr, vecs[i].addr);
                chk($sformatf("v%0d_funct3", i), f3s,  vecs[i].f3);
            end
            if (vecs[i].nwr > 0)
                chk($sformatf("v%0d_value", i), val, vecs[i].val);
        end

        // Backpressure: response held for five cycles while a second request waits.
        @(negedge clk);
        drive_req(32'd0, 32'd12, 32'd0, 1'b1, 1'b0, 3'd2, 5'd9);
        @(posedge clk);
        #1 drive_req(32'd3, 32'd0, 32'h77, 1'b0, 1'b1, 3'd0, 5'd1);
        repeat (3) @(negedge clk);
        chk("bp_first_valid", bus.resp_valid, 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("bp%0d_valid", k), bus.resp_valid, 32'd1);
            chk($sformatf("bp%0d_data", k),  bus.resp_data,  32'hDEADBEEF);
            chk($sformatf("bp%0d_rd", k),    bus.resp_rd,    32'd9);
            chk($sformatf("bp%0d_ready", k), bus.req_ready,  32'd0);
            chk($sformatf("bp%0d_write", k), bus.mem_write,  32'd0);
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        bus.resp_ready = 1'b0;
        chk("bp_done_valid", bus.resp_valid, 32'd0);
        chk("bp_done_ready", bus.req_ready,  32'd1);
        chk("bp_done_write", bus.mem_write,  32'd0);
        bus.req_valid = 1'b0;

        // Reset while a store sits in ACCESS.
        @(negedge clk);
        drive_req(32'd10, 32'd0, 32'h99, 1'b0, 1'b1, 3'd2, 5'd3);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        chk("rs_write_before", bus.mem_write, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("rs_write_drop",  bus.mem_write,  32'd0);
        chk("rs_addr_drop",   bus.mem_addr,   32'd0);
        chk("rs_req_ready",   bus.req_ready,  32'd1);
        chk("rs_resp_valid",  bus.resp_valid, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        nresp = 0;
        bus.resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (bus.resp_valid) nresp++;
        end
        chk("rs_no_resp",  nresp,         32'd0);
        chk("rs_ready_up", bus.req_ready, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter MEMSIZE, default 64, giving the number of data-memory entries; legal effective addresses are 0..MEMSIZE-1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have ports req_valid (input, 1) and req_ready (output, 1): request handshake.
REQ-005 SHALL have ports is_load and is_store, inputs, 1 bit each: operation type.
REQ-006 SHALL have ports base and offset (inputs, 32 each), store_data (input, 32), funct3 (input, 3) and rd (input, 5): the request payload.
REQ-007 SHALL have ports mem_addr (output, 32), mem_value (output, 32), mem_funct3 (output, 3), mem_read (output, 1) and mem_write (output, 1): the data-memory drive.
REQ-008 SHALL have port mem_data, input, 32 bits: registered data-memory read result, valid one cycle after mem_read.
REQ-009 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1): response handshake.
REQ-010 SHALL have ports resp_data (output, 32), resp_rd (output, 5) and resp_fault (output, 1): the response payload.

Function
REQ-011 SHALL implement states IDLE, ACCESS, WAIT, RESP.
REQ-012 SHALL assert req_ready only in IDLE; a request is accepted on a rising edge where req_valid and req_ready are both 1.
REQ-013 SHALL register ea = base + offset (modulo 2^32), store_data, funct3, rd, is_load and is_store on acceptance.
REQ-014 SHALL mark the request as faulting when any of the following holds: ea >= MEMSIZE; is_load == is_store; a load with funct3 in {3,6,7}; a store with funct3 > 2.
REQ-015 On acceptance of a faulting request, SHALL go IDLE->RESP with resp_fault=1 and resp_data=0, issuing no memory access.
REQ-016 On acceptance of a legal request, SHALL go IDLE->ACCESS; in ACCESS it SHALL drive mem_addr=ea, mem_funct3=funct3 and mem_value=store_data, and assert exactly one of mem_read or mem_write for exactly one cycle.
REQ-017 SHALL go ACCESS->WAIT for a load and ACCESS->RESP for a store.
REQ-018 In WAIT, SHALL capture mem_data into resp_data and go WAIT->RESP.
REQ-019 For a store, SHALL return resp_data=0.
REQ-020 In RESP, SHALL hold resp_valid=1 with a stable payload until resp_ready=1, then return to IDLE.
REQ-021 SHALL NOT accept a new request in the cycle resp_ready completes; req_ready rises the following cycle.
REQ-022 Latency from acceptance edge to resp_valid: load 3 cycles, store 2 cycles, fault 1 cycle.
REQ-023 SHALL hold mem_read and mem_write at 0 and mem_addr, mem_value and mem_funct3 at 0 outside ACCESS.
REQ-024 SHALL ignore req_valid while not in IDLE.

Reset
REQ-025 While rst=1, SHALL hold the state at IDLE and hold req_ready=1, resp_valid=0, resp_data=0, resp_rd=0, resp_fault=0, mem_read=0, mem_write=0, mem_addr=0, mem_value=0 and mem_funct3=0, independent of clk.
REQ-026 On reset asserted mid-operation, SHALL discard the in-flight request with no response, and SHALL deassert any pending mem_write immediately.

Configuration
REQ-027 SHALL recognise the macro MISALIGN_TRAP_EN.
REQ-028 When MISALIGN_TRAP_EN is defined, SHALL also treat the following as faulting: halfword accesses (funct3 1 or 5) with ea[0]=1, and word accesses (funct3 2) with ea[1:0]!=0.
REQ-029 When MISALIGN_TRAP_EN is undefined, SHALL issue misaligned accesses to memory unchanged, with no fault.

Verification
REQ-030 Load word: base=8, offset=4, funct3=2, mem_data=0xDEADBEEF -> mem_addr=12, mem_read high for 1 cycle, resp_valid 3 cycles after acceptance, resp_data=0xDEADBEEF, resp_fault=0.
REQ-031 Store byte: base=3, offset=0, funct3=0, store_data=0x55 -> mem_write high for 1 cycle with mem_addr=3 and mem_value=0x55; resp_valid 2 cycles after acceptance; resp_data=0.
REQ-032 Out of range: base=60, offset=8, MEMSIZE=64 -> no mem_read/mem_write, resp_fault=1 one cycle after acceptance.
REQ-033 Backpressure: hold resp_ready=0 for 5 cycles -> resp_valid and payload stable, req_ready=0 throughout, and a new request with req_valid=1 is ignored.
REQ-034 Misaligned: funct3=2, ea=6 -> resp_fault=1 with MISALIGN_TRAP_EN defined; mem_read issued at mem_addr=6 without it.
REQ-035 Reset pulse during ACCESS of a store -> mem_write drops to 0 immediately, no resp_valid occurs, and req_ready=1.
